// File: rtl/sha3_feeder_pkg.sv
// rtl/sha3_feeder_pkg.sv - shared types, padding constants and helpers for the SHA-3 burst feeder
package sha3_feeder_pkg;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        FILL,
        PAD,
        SEND,
        WAIT_HASH,
        DONE
    } state_t;

    localparam logic [7:0] DSBYTE  = 8'h06;
    localparam logic [7:0] ENDBYTE = 8'h80;

    function automatic logic [31:0] ceil_div(input logic [31:0] a, input logic [31:0] b);
        return (a + b - 32'd1) / b;
    endfunction

endpackage

// File: rtl/sha3_block_packer.sv
// rtl/sha3_block_packer.sv - rate-sized block buffer with beat write, tail masking and pad insert
module sha3_block_packer
    import sha3_feeder_pkg::*;
#(
    parameter int BUS_W      = 64,
    parameter int RATE_BYTES = 72
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    clr,
    input  logic                    wr_en,
    input  logic [7:0]              wr_beat,
    input  logic [BUS_W-1:0]        wr_data,
    input  logic [31:0]             wr_byte_base,
    input  logic [31:0]             msg_len,
    input  logic                    pad_en,
    input  logic [31:0]             pad_pos,
    output logic [RATE_BYTES*8-1:0] blk_data
);

    localparam int BPB = BUS_W / 8;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            blk_data <= '0;
        end else if (clr) begin
            blk_data <= '0;
        end else if (wr_en) begin
            // bytes past the end of the message are forced to zero so padding lands on a clean tail
            for (int k = 0; k < BPB; k++) begin
                blk_data[(int'(wr_beat) * BPB + k) * 8 +: 8] <=
                    ((wr_byte_base + 32'(k)) < msg_len) ? wr_data[8*k +: 8] : 8'h00;
            end
        end else if (pad_en) begin
            // both XORs per byte so a shared position yields 0x86
            for (int i = 0; i < RATE_BYTES; i++) begin
                blk_data[8*i +: 8] <= blk_data[8*i +: 8]
                                    ^ ((pad_pos == 32'(i)) ? DSBYTE : 8'h00)
                                    ^ ((i == RATE_BYTES - 1) ? ENDBYTE : 8'h00);
            end
        end
    end

endmodule

// File: rtl/sha3_burst_feeder.sv
// rtl/sha3_burst_feeder.sv - fetches a message in rate-sized bursts, pads it and feeds Keccak blocks
module sha3_burst_feeder
    import sha3_feeder_pkg::*;
#(
    parameter int BUS_W      = 64,
    parameter int RATE_BYTES = 72,
    parameter int HASH_BITS  = 512,
    parameter int LEN_W      = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic [LEN_W-1:0]        number_bytes,
    output logic                    init_master_txn,
    output logic [31:0]             read_addr_index,
    output logic [7:0]              burst_beats,
    input  logic [BUS_W-1:0]        bus_data,
    input  logic                    bus_data_valid,
    output logic                    dfsm_read_ready,
    input  logic                    read_done,
    output logic [RATE_BYTES*8-1:0] blk_data,
    output logic                    blk_valid,
    output logic                    blk_last,
    input  logic                    blk_ready,
    input  logic [HASH_BITS-1:0]    hash_in,
    input  logic                    hash_valid,
    output logic [HASH_BITS-1:0]    keccak_hash_reg,
    output logic                    busy,
    output logic                    done
);

    localparam int BPB   = BUS_W / 8;
    localparam int BEATS = RATE_BYTES / BPB;

    state_t             state;
    logic [LEN_W-1:0]   n_reg;
    logic [31:0]        total_beats;
    logic [31:0]        beat_idx;
    logic [31:0]        blk_base;
    logic [7:0]         beat_cnt;

    logic [31:0]        rem_beats;
    logic [7:0]         burst_calc;
    logic               is_final;
    logic               beat_take;
    logic               buf_clr;

    // beat_idx and blk_base always point at the start of the current block
    assign rem_beats       = total_beats - beat_idx;
    assign burst_calc      = (rem_beats > 32'(BEATS)) ? 8'(BEATS) : rem_beats[7:0];
    assign is_final        = 32'(n_reg) < (blk_base + 32'(RATE_BYTES));
    assign dfsm_read_ready = (state == FILL) && (beat_cnt < burst_beats);
    assign beat_take       = bus_data_valid && dfsm_read_ready;
    assign busy            = (state != IDLE);
    assign buf_clr         = ((state == IDLE) && start) ||
                             ((state == SEND) && blk_ready && !blk_last);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state           <= IDLE;
            n_reg           <= '0;
            total_beats     <= '0;
            beat_idx        <= '0;
            blk_base        <= '0;
            beat_cnt        <= '0;
            init_master_txn <= 1'b0;
            read_addr_index <= '0;
            burst_beats     <= '0;
            blk_valid       <= 1'b0;
            blk_last        <= 1'b0;
            done            <= 1'b0;
            keccak_hash_reg <= '0;
        end else begin
            init_master_txn <= 1'b0;
            done            <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        n_reg       <= number_bytes;
                        total_beats <= ceil_div(32'(number_bytes), 32'(BPB));
                        beat_idx    <= '0;
                        blk_base    <= '0;
                        state       <= REQ;
                    end
                end
                REQ: begin
                    beat_cnt <= '0;
                    // a block-aligned message leaves a padding-only final block with nothing to fetch
                    if (rem_beats != 32'd0) begin
                        read_addr_index <= beat_idx;
                        burst_beats     <= burst_calc;
                        init_master_txn <= 1'b1;
                        state           <= FILL;
                    end else begin
                        state <= PAD;
                    end
                end
                FILL: begin
                    if (beat_take) begin
                        beat_cnt <= beat_cnt + 8'd1;
                    end
                    if (read_done) begin
                        if (is_final) begin
                            state <= PAD;
                        end else begin
                            blk_valid <= 1'b1;
                            blk_last  <= 1'b0;
                            state     <= SEND;
                        end
                    end
                end
                PAD: begin
                    blk_valid <= 1'b1;
                    blk_last  <= 1'b1;
                    state     <= SEND;
                end
                SEND: begin
                    if (blk_ready) begin
                        blk_valid <= 1'b0;
                        blk_last  <= 1'b0;
                        if (blk_last) begin
                            state <= WAIT_HASH;
                        end else begin
                            blk_base <= blk_base + 32'(RATE_BYTES);
                            beat_idx <= beat_idx + 32'(BEATS);
                            state    <= REQ;
                        end
                    end
                end
                WAIT_HASH: begin
                    if (hash_valid) begin
                        keccak_hash_reg <= hash_in;
                        done            <= 1'b1;
                        state           <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    sha3_block_packer #(
        .BUS_W      (BUS_W),
        .RATE_BYTES (RATE_BYTES)
    ) u_packer (
        .clk          (clk),
        .resetn       (reset),
        .clr          (buf_clr),
        .wr_en        (beat_take),
        .wr_beat      (beat_cnt),
        .wr_data      (bus_data),
        .wr_byte_base ((beat_idx + 32'(beat_cnt)) * 32'(BPB)),
        .msg_len      (32'(n_reg)),
        .pad_en       (state == PAD),
        .pad_pos      (32'(n_reg) - blk_base),
        .blk_data     (blk_data)
    );

endmodule

// File: tb/tb_sha3_burst_feeder.sv
// tb/tb_sha3_burst_feeder.sv - self-checking bench for sha3_burst_feeder against a padded-message model
module tb_sha3_burst_feeder;

    localparam int BW    = 64;
    localparam int R     = 72;
    localparam int HB    = 512;
    localparam int LW    = 16;
    localparam int BPB   = BW / 8;
    localparam int BEATS = R / BPB;
    localparam int CW    = (R * 8 > HB) ? R * 8 : HB;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              start = 1'b0;
    logic [LW-1:0]     number_bytes = '0;
    logic              init_master_txn;
    logic [31:0]       read_addr_index;
    logic [7:0]        burst_beats;
    logic [BW-1:0]     bus_data = '0;
    logic              bus_data_valid = 1'b0;
    logic              dfsm_read_ready;
    logic              read_done = 1'b0;
    logic [R*8-1:0]    blk_data;
    logic              blk_valid;
    logic              blk_last;
    logic              blk_ready = 1'b0;
    logic [HB-1:0]     hash_in = '0;
    logic              hash_valid = 1'b0;
    logic [HB-1:0]     keccak_hash_reg;
    logic              busy;
    logic              done;

    int checks = 0;
    int errors = 0;

    logic [7:0] mem  [0:511];
    logic [7:0] expb [0:511];

    always #5 clk = ~clk;

    sha3_burst_feeder #(
        .BUS_W(BW), .RATE_BYTES(R), .HASH_BITS(HB), .LEN_W(LW)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .number_bytes(number_bytes),
        .init_master_txn(init_master_txn), .read_addr_index(read_addr_index),
        .burst_beats(burst_beats), .bus_data(bus_data), .bus_data_valid(bus_data_valid),
        .dfsm_read_ready(dfsm_read_ready), .read_done(read_done), .blk_data(blk_data),
        .blk_valid(blk_valid), .blk_last(blk_last), .blk_ready(blk_ready),
        .hash_in(hash_in), .hash_valid(hash_valid), .keccak_hash_reg(keccak_hash_reg),
        .busy(busy), .done(done)
    );

    task automatic check(input string tag, input logic [CW-1:0] obs, input logic [CW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [BW-1:0] beat_word(input int idx);
        logic [BW-1:0] w;
        for (int k = 0; k < BPB; k++) w[8*k +: 8] = mem[idx*BPB + k];
        return w;
    endfunction

    function automatic logic [R*8-1:0] exp_block(input int b);
        logic [R*8-1:0] e;
        for (int i = 0; i < R; i++) e[8*i +: 8] = expb[b*R + i];
        return e;
    endfunction

    // memory holds random bytes everywhere, including past N, so tail masking is exercised
    task automatic run_hash(input int n, input int stall, input bit noise, input bit pat16);
        int nb, tbeats, exp_bursts, blk, bursts, budget, eb;
        logic [HB-1:0] h;
        nb = n / R + 1;
        tbeats = (n + BPB - 1) / BPB;
        exp_bursts = (tbeats + BEATS - 1) / BEATS;
        for (int i = 0; i < 512; i++) mem[i] = 8'($urandom);
        if (pat16) begin
            for (int i = 0; i < 16; i++) mem[i] = 8'h00;
            mem[8] = 8'h01;
        end
        for (int i = 0; i < 512; i++) expb[i] = (i < n) ? mem[i] : 8'h00;
        expb[n] = expb[n] ^ 8'h06;
        expb[nb*R - 1] = expb[nb*R - 1] ^ 8'h80;

        number_bytes = LW'(n);
        start = 1'b1;
        tick();
        start = 1'b0;
        blk = 0; bursts = 0; budget = 0;
        while (blk < nb && budget < 3000) begin
            budget++;
            if (init_master_txn) begin
                eb = (tbeats - blk*BEATS < BEATS) ? tbeats - blk*BEATS : BEATS;
                check($sformatf("addr n=%0d b=%0d", n, blk), CW'(read_addr_index), CW'(blk*BEATS));
                check($sformatf("beats n=%0d b=%0d", n, blk), CW'(burst_beats), CW'(eb));
                bursts++;
                for (int j = 0; j < eb; j++) begin
                    bus_data = beat_word(blk*BEATS + j);
                    bus_data_valid = 1'b1;
                    read_done = (!noise && j == eb - 1);
                    check("rd_ready", CW'(dfsm_read_ready), CW'(1));
                    tick();
                end
                if (noise) begin
                    bus_data = '1;
                    bus_data_valid = 1'b1;
                    read_done = 1'b1;
                    check("rd_ready_full", CW'(dfsm_read_ready), CW'(0));
                    tick();
                end
                bus_data_valid = 1'b0;
                read_done = 1'b0;
            end else if (blk_valid) begin
                check($sformatf("blk n=%0d b=%0d", n, blk), CW'(blk_data), CW'(exp_block(blk)));
                check($sformatf("last n=%0d b=%0d", n, blk), CW'(blk_last), CW'(blk == nb - 1));
                for (int s = 0; s < stall; s++) begin
                    bus_data = '1;
                    bus_data_valid = 1'b1;
                    start = 1'b1;
                    number_bytes = LW'($urandom);
                    tick();
                    check("stall_valid", CW'(blk_valid), CW'(1));
                    check("stall_data", CW'(blk_data), CW'(exp_block(blk)));
                    check("stall_last", CW'(blk_last), CW'(blk == nb - 1));
                end
                bus_data_valid = 1'b0;
                start = 1'b0;
                blk_ready = 1'b1;
                tick();
                blk_ready = 1'b0;
                blk++;
            end else begin
                tick();
            end
        end
        check($sformatf("blocks n=%0d", n), CW'(blk), CW'(nb));
        check($sformatf("bursts n=%0d", n), CW'(bursts), CW'(exp_bursts));
        check("busy_wait", CW'(busy), CW'(1));
        h = {16{$urandom}};
        hash_in = h;
        hash_valid = 1'b1;
        tick();
        hash_valid = 1'b0;
        check("done_pulse", CW'(done), CW'(1));
        check("hash_reg", CW'(keccak_hash_reg), CW'(h));
        tick();
        check("done_clear", CW'(done), CW'(0));
        check("idle", CW'(busy), CW'(0));
        check("hash_hold", CW'(keccak_hash_reg), CW'(h));
    endtask

    initial begin
        reset = 1'b0;
        tick();
        tick();
        check("rst_busy", CW'(busy), CW'(0));
        check("rst_blk", CW'(blk_data), CW'(0));
        check("rst_hash", CW'(keccak_hash_reg), CW'(0));
        check("rst_valid", CW'(blk_valid), CW'(0));
        check("rst_init", CW'(init_master_txn), CW'(0));
        reset = 1'b1;
        tick();

        run_hash(0, 0, 1'b0, 1'b0);
        run_hash(16, 0, 1'b0, 1'b1);
        run_hash(71, 0, 1'b1, 1'b0);
        run_hash(72, 0, 1'b0, 1'b0);
        run_hash(100, 5, 1'b1, 1'b0);
        run_hash(100, 0, 1'b0, 1'b0);

        // abort in the middle of a burst
        number_bytes = 16'd100;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 0; c < 20 && !init_master_txn; c++) tick();
        check("rst_test_init", CW'(init_master_txn), CW'(1));
        for (int j = 0; j < 3; j++) begin
            bus_data = {2{$urandom}};
            bus_data_valid = 1'b1;
            tick();
        end
        reset = 1'b0;
        tick();
        check("abort_busy", CW'(busy), CW'(0));
        check("abort_blk", CW'(blk_data), CW'(0));
        check("abort_hash", CW'(keccak_hash_reg), CW'(0));
        check("abort_ready", CW'(dfsm_read_ready), CW'(0));
        check("abort_beats", CW'(burst_beats), CW'(0));
        check("abort_addr", CW'(read_addr_index), CW'(0));
        check("abort_valid", CW'(blk_valid), CW'(0));
        check("abort_last", CW'(blk_last), CW'(0));
        check("abort_done", CW'(done), CW'(0));
        reset = 1'b1;
        read_done = 1'b1;
        hash_in = {16{32'hdeadbeef}};
        hash_valid = 1'b1;
        tick();
        bus_data_valid = 1'b0;
        read_done = 1'b0;
        hash_valid = 1'b0;
        check("post_busy", CW'(busy), CW'(0));
        check("post_blk", CW'(blk_data), CW'(0));
        check("idle_hash_ignored", CW'(keccak_hash_reg), CW'(0));
        run_hash(16, 0, 1'b0, 1'b0);

        for (int r = 0; r < 6; r++) begin
            run_hash(int'($urandom_range(0, 300)), int'($urandom_range(0, 3)),
                     1'($urandom_range(0, 1)), 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sha3_burst_feeder.md
Name: sha3_burst_feeder

Overview:
- Parametrised successor to the SHA-3 data FSM.
- Fetches a message of `number_bytes` bytes from on-chip memory through the burst-read master, one rate-sized block per burst.
- Packs the beats into a block and applies SHA-3 padding (0x06 … 0x80) in hardware, then hands each block to the Keccak core with a valid/ready handshake.
- Latches the final digest into `keccak_hash_reg`.

Parameters:
- BUS_W, 64, read-data beat width in bits; must divide RATE_BYTES*8 and be a multiple of 8.
- RATE_BYTES, 72, sponge rate in bytes (72 = SHA3-512, 136 = SHA3-256).
- HASH_BITS, 512, digest width.
- LEN_W, 16, width of the message-length field.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-low reset
- start  in  1  one-cycle pulse; begin hashing; ignored unless idle
- number_bytes  in  LEN_W  message length; sampled on accepted start
- init_master_txn  out  1  one-cycle pulse requesting a burst
- read_addr_index  out  32  beat index of first beat of the burst (0-based from message start)
- burst_beats  out  8  beats requested in this burst
- bus_data  in  BUS_W  read beat; byte k = bits [8k+7:8k]
- bus_data_valid  in  1  beat valid
- dfsm_read_ready  out  1  block accepts beats
- read_done  in  1  burst complete
- blk_data  out  RATE_BYTES*8  padded block to Keccak
- blk_valid  out  1  block valid
- blk_last  out  1  final block of message
- blk_ready  in  1  Keccak accepts block
- hash_in  in  HASH_BITS  Keccak digest
- hash_valid  in  1  digest valid
- keccak_hash_reg  out  HASH_BITS  latched digest
- busy  out  1  not idle
- done  out  1  one-cycle pulse when digest latched

Behaviour:
- Reset (reset==0 at a clk edge): state IDLE; every output 0, including keccak_hash_reg and blk_data. Reset mid-operation aborts immediately; beats and handshakes still in flight are ignored afterwards.
- Derived: BEATS = RATE_BYTES*8/BUS_W; N = number_bytes; total beats TB = ceil(N*8/BUS_W); blocks NB = floor(N/RATE_BYTES)+1. Counters: beat index (32b), block index, beat-in-block.
- IDLE: on start, latch N, clear the block buffer, go to REQ.
- REQ:
  - If beats remain, drive read_addr_index = current beat index and burst_beats = min(BEATS, beats remaining), pulse init_master_txn for 1 cycle, go to FILL.
  - If no beats remain (final block with N mod RATE_BYTES == 0, or N == 0), go to PAD without a request.
- FILL:
  - dfsm_read_ready = 1 while beats received < burst_beats.
  - Each bus_data_valid && dfsm_read_ready writes the beat to blk_data[BUS_W*j +: BUS_W].
  - Bytes at message offset ≥ N are written as 0.
  - Beats beyond burst_beats, or arriving with dfsm_read_ready low, are dropped.
  - On read_done, go to PAD if this is the final block, else SEND.
  - read_done and the last beat arriving in the same cycle: the beat is captured, then the transition is taken.
- PAD (final block only, 1 cycle): byte (N mod RATE_BYTES) ^= 0x06 and byte RATE_BYTES-1 ^= 0x80. When these are the same byte the result is 0x86. Go to SEND.
- SEND:
  - blk_valid = 1; blk_data and blk_last are stable until blk_valid && blk_ready.
  - On acceptance: if final, go to WAIT_HASH; else clear the buffer, increment the block index, go to REQ.
  - blk_last = (block index == NB-1).
- WAIT_HASH: on hash_valid, keccak_hash_reg <= hash_in, go to DONE. hash_valid seen in any other state is ignored.
- DONE: done = 1 for one cycle, go to IDLE. keccak_hash_reg holds its value until the next reset or the next digest.
- busy = (state != IDLE).
- Minimum latency per full block: 2 + burst beats + 1 cycles to blk_valid.

Decomposition:
- Package sha3_feeder_pkg: state enum (IDLE, REQ, FILL, PAD, SEND, WAIT_HASH, DONE), padding constants DSBYTE=8'h06 and ENDBYTE=8'h80, and a ceil-div function.
- One sub-module, sha3_block_packer: block buffer with beat write, byte masking, pad-insert and clear. The FSM stays in the top level.

Test Plan:
- N=0, BUS_W=64, RATE=72 → no init_master_txn; one block with byte0=0x06, byte71=0x80, rest 0; blk_last=1; hash latched and done pulsed.
- N=16, beats 64'd0 then 64'd1 → burst_beats=2, read_addr_index=0; block bytes 0..15 equal the data, byte16=0x06, byte71=0x80, blk_last=1.
- N=71 → byte71=0x86; N=72 → two blocks, the second padding-only with no burst issued, only it has blk_last=1.
- N=100 → bursts at index 0 (9 beats) and index 9 (4 beats); bytes 100..103 of beat 12 zeroed; pad at byte 28 of block 1.
- blk_ready held low 5 cycles in SEND → blk_data/blk_valid/blk_last stable; extra bus_data_valid beats and a start pulse in that window are ignored.
- reset=0 during FILL → next cycle all outputs 0, state IDLE; a subsequent start with N=16 completes normally.
